// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the byte-wide RAM port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    // Which pipeline stage owns the transfer in flight.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    // mem_len encodings: byte count minus one.
    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Byte count for a MEM length code; the illegal code 2 behaves as a word.
    function automatic logic [2:0] len_to_count(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Single owner of the byte-wide RAM port. Serializes IF word
//             fetches and MEM byte/half/word loads and stores into per-byte
//             RAM cycles. MEM has priority; IF reads may be flushed.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // fetch stage
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_data,
    // memory stage
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    // RAM pins
    input  logic [7:0]        ram_din,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout
);

    arb_state_t        r_state, w_state;
    arb_owner_t        r_owner, w_owner;
    logic [ADDR_W-1:0] r_base,  w_base;
    logic [2:0]        r_n,     w_n;      // bytes in this transfer, 1..4
    logic [31:0]       r_wdata, w_wdata;
    logic [2:0]        r_cnt,   w_cnt;    // next byte index to issue
    logic [1:0]        r_rcv,   w_rcv;    // next byte index to capture
    logic              r_cap,   w_cap;    // ram_din carries valid read data
    logic [31:0]       r_buf,   w_buf;    // bytes captured so far

    logic [ADDR_W-1:0] w_ram_a;
    logic              w_ram_wr;
    logic [7:0]        w_ram_dout;
    logic              w_if_done, w_mem_done;
    logic [31:0]       w_if_data, w_mem_rdata;

    logic [31:0]       w_merged;          // capture buffer with ram_din dropped in
    logic [7:0]        w_wbyte;           // store byte selected by issue index
    logic [ADDR_W-1:0] w_next_addr;

    assign w_next_addr = r_base + ADDR_W'(r_cnt);

    // Byte steering: place the incoming read byte and select the outgoing store byte.
    always_comb begin
        w_merged = r_buf;
        case (r_rcv)
            2'd0:    w_merged[7:0]   = ram_din;
            2'd1:    w_merged[15:8]  = ram_din;
            2'd2:    w_merged[23:16] = ram_din;
            default: w_merged[31:24] = ram_din;
        endcase
        case (r_cnt[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        w_state     = r_state;
        w_owner     = r_owner;
        w_base      = r_base;
        w_n         = r_n;
        w_wdata     = r_wdata;
        w_cnt       = r_cnt;
        w_rcv       = r_rcv;
        w_cap       = r_cap;
        w_buf       = r_buf;
        w_ram_a     = ram_a;
        w_ram_wr    = ram_wr;
        w_ram_dout  = ram_dout;
        w_if_done   = 1'b0;
        w_mem_done  = 1'b0;
        w_if_data   = if_data;
        w_mem_rdata = mem_rdata;

        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_owner    = OWN_MEM;
                    w_base     = mem_addr;
                    w_n        = len_to_count(mem_len);
                    w_wdata    = mem_wdata;
                    w_ram_a    = mem_addr;
                    w_ram_wr   = mem_we;
                    w_ram_dout = mem_wdata[7:0];
                    w_cnt      = 3'd1;
                    w_rcv      = 2'd0;
                    w_cap      = 1'b0;
                    w_buf      = ZeroWord;
                    w_state    = mem_we ? WR : RD;
                end else if (if_req && !if_flush) begin
                    w_owner  = OWN_IF;
                    w_base   = if_addr;
                    w_n      = 3'd4;
                    w_ram_a  = if_addr;
                    w_ram_wr = 1'b0;
                    w_cnt    = 3'd1;
                    w_rcv    = 2'd0;
                    w_cap    = 1'b0;
                    w_buf    = ZeroWord;
                    w_state  = RD;
                end
            end
            RD: begin
                if (r_owner == OWN_IF && if_flush) begin
                    // Abandon the fetch; partially captured bytes are dropped.
                    w_state = IDLE;
                    w_ram_a = '0;
                    w_cnt   = 3'd0;
                    w_rcv   = 2'd0;
                    w_cap   = 1'b0;
                end else begin
                    if (r_cnt < r_n) begin
                        w_ram_a = w_next_addr;
                        w_cnt   = r_cnt + 3'd1;
                    end
                    // RAM returns data one edge after it samples the address.
                    w_cap = 1'b1;
                    if (r_cap) begin
                        if ({1'b0, r_rcv} == r_n - 3'd1) begin
                            w_state = DONE;
                            w_ram_a = '0;
                            if (r_owner == OWN_IF) begin
                                w_if_done = 1'b1;
                                w_if_data = w_merged;
                            end else begin
                                w_mem_done  = 1'b1;
                                w_mem_rdata = w_merged;
                            end
                        end else begin
                            w_buf = w_merged;
                            w_rcv = r_rcv + 2'd1;
                        end
                    end
                end
            end
            WR: begin
                if (r_cnt < r_n) begin
                    w_ram_a    = w_next_addr;
                    w_ram_dout = w_wbyte;
                    w_cnt      = r_cnt + 3'd1;
                end else begin
                    w_ram_wr   = 1'b0;
                    w_ram_a    = '0;
                    w_state    = DONE;
                    w_mem_done = 1'b1;
                end
            end
            default: begin
                // DONE: requester drops its request during this cycle.
                w_state = IDLE;
                w_cnt   = 3'd0;
                w_rcv   = 2'd0;
                w_cap   = 1'b0;
            end
        endcase
    end

    // State and registered RAM/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= OWN_IF;
            r_base    <= '0;
            r_n       <= 3'd0;
            r_wdata   <= ZeroWord;
            r_cnt     <= 3'd0;
            r_rcv     <= 2'd0;
            r_cap     <= 1'b0;
            r_buf     <= ZeroWord;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'h00;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= ZeroWord;
            mem_rdata <= ZeroWord;
        end else begin
            r_state   <= w_state;
            r_owner   <= w_owner;
            r_base    <= w_base;
            r_n       <= w_n;
            r_wdata   <= w_wdata;
            r_cnt     <= w_cnt;
            r_rcv     <= w_rcv;
            r_cap     <= w_cap;
            r_buf     <= w_buf;
            ram_a     <= w_ram_a;
            ram_wr    <= w_ram_wr;
            ram_dout  <= w_ram_dout;
            if_done   <= w_if_done;
            mem_done  <= w_mem_done;
            if_data   <= w_if_data;
            mem_rdata <= w_mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter with a byte RAM model,
//             directed vector table, corner-case sequences and random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  ram_din;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;

    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;
    bit   [8:0]  ram [0:65535];   // bit 8 marks a byte that has been written
    int          wr_count;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          flush;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs [13];

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Content of the byte RAM; unwritten bytes follow a fixed address hash.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        bit [8:0] e;
        e = ram[a[15:0]];
        if (e[8]) return e[7:0];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // RAM: samples pins at posedge, read data valid until the next posedge.
    always @(posedge clk) begin
        ram_din <= ram_byte(ram_a);
        if (pre_we) begin
            ram[pre_addr] <= {1'b1, pre_data};
        end else if (ram_wr) begin
            ram[ram_a[15:0]] <= {1'b1, ram_dout};
            wr_count <= wr_count + 1;
        end
    end

    function automatic int byte_count(input bit is_if, input logic [1:0] len);
        if (is_if) return 4;
        if (len == LEN_B) return 1;
        if (len == LEN_H) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ram_byte(addr + 32'(i))) << (8 * i));
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a[15:0];
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // One complete transfer: drive, watch the pins, check latency and data.
    task automatic xact(input bit is_if, input bit we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit flush, input int exp_lat, input logic [31:0] exp_data,
                        input string tag);
        int   n;
        int   cyc;
        bit   seen;
        logic dn;
        n = byte_count(is_if, len);
        @(negedge clk);
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_len   = len;
            mem_addr  = addr;
            mem_wdata = wdata;
        end
        if_flush = flush;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 16) begin
            @(negedge clk);
            cyc++;
            if (cyc <= n) begin
                chk({tag, " ram_a"}, ram_a, addr + 32'(cyc - 1));
                if (we) begin
                    chk({tag, " ram_wr"}, {31'b0, ram_wr}, 32'h1);
                    chk({tag, " ram_dout"}, {24'b0, ram_dout}, (wdata >> (8 * (cyc - 1))) & 32'hFF);
                end
            end
            dn = is_if ? if_done : mem_done;
            if (dn) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, " done timeout"}, 32'h0, 32'h1);
        end else begin
            chk({tag, " latency"}, 32'(cyc - 1), 32'(exp_lat));
            chk({tag, " other done"}, {31'b0, is_if ? mem_done : if_done}, 32'h0);
            chk({tag, " ram_a idle"}, ram_a, 32'h0);
            chk({tag, " ram_wr idle"}, {31'b0, ram_wr}, 32'h0);
            if (we) begin
                for (int i = 0; i < n; i++)
                    chk({tag, " ram byte"}, {24'b0, ram_byte(addr + 32'(i))},
                        (exp_data >> (8 * i)) & 32'hFF);
            end else begin
                chk({tag, " rdata"}, is_if ? if_data : mem_rdata, exp_data);
            end
        end
        if_req   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        if_flush = 1'b0;
        @(negedge clk);
        dn = is_if ? if_done : mem_done;
        chk({tag, " done pulse"}, {31'b0, dn}, 32'h0);
        if (!we && seen)
            chk({tag, " rdata held"}, is_if ? if_data : mem_rdata, exp_data);
    endtask

    int          cyc;
    bit          seen, any_done;
    int          snap;
    bit          r_is_if, r_we, r_flush;
    logic [1:0]  r_len;
    logic [31:0] r_addr, r_wdata, r_exp;
    int          r_n, r_lat;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, LEN_W, 32'h0000_0100, 32'h0,         1'b0, 5, 32'h4433_2211};
        vecs[1]  = '{1'b0, 1'b1, LEN_H, 32'h0000_2001, 32'h1234_BEEF, 1'b0, 2, 32'h0000_BEEF};
        vecs[2]  = '{1'b0, 1'b0, LEN_B, 32'h0000_0080, 32'h0,         1'b0, 2, 32'h0000_00F0};
        vecs[3]  = '{1'b0, 1'b0, LEN_H, 32'h0000_0101, 32'h0,         1'b0, 3, 32'h0000_3322};
        vecs[4]  = '{1'b0, 1'b0, 2'd2,  32'h0000_0300, 32'h0,         1'b0, 5, 32'h8D7C_6B5A};
        vecs[5]  = '{1'b1, 1'b0, LEN_W, 32'h0000_0100, 32'h0,         1'b0, 5, 32'h4433_2211};
        vecs[6]  = '{1'b0, 1'b0, LEN_W, 32'hFFFF_FFFE, 32'h0,         1'b0, 5, 32'hD4C3_B2A1};
        vecs[7]  = '{1'b0, 1'b1, LEN_W, 32'h0000_0400, 32'hCAFE_F00D, 1'b0, 4, 32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 1'b1, LEN_B, 32'h0000_0500, 32'hFFFF_FFAB, 1'b0, 1, 32'h0000_00AB};
        vecs[9]  = '{1'b0, 1'b0, LEN_W, 32'h0000_0100, 32'h0,         1'b1, 5, 32'h4433_2211};
        vecs[10] = '{1'b0, 1'b0, LEN_W, 32'h0000_0400, 32'h0,         1'b0, 5, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 1'b0, LEN_W, 32'hFFFF_FFFE, 32'h0,         1'b0, 5, 32'hD4C3_B2A1};
        vecs[12] = '{1'b0, 1'b0, LEN_H, 32'h0000_2001, 32'h0,         1'b0, 3, 32'h0000_BEEF};

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
        pre_we = 1'b0; pre_addr = 16'h0; pre_data = 8'h0;

        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        preload(32'h080, 8'hF0);
        preload(32'h300, 8'h5A); preload(32'h301, 8'h6B);
        preload(32'h302, 8'h7C); preload(32'h303, 8'h8D);
        preload(32'hFFFF_FFFE, 8'hA1); preload(32'hFFFF_FFFF, 8'hB2);
        preload(32'h0, 8'hC3); preload(32'h1, 8'hD4);
        preload(32'h603, 8'h77);

        @(negedge clk);
        chk("reset ram_a", ram_a, 32'h0);
        chk("reset ram_wr", {31'b0, ram_wr}, 32'h0);
        chk("reset ram_dout", {24'b0, ram_dout}, 32'h0);
        chk("reset dones", {30'b0, if_done, mem_done}, 32'h0);
        chk("reset if_data", if_data, 32'h0);
        chk("reset mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 13; i++)
            xact(vecs[i].is_if, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata,
                 vecs[i].flush, vecs[i].exp_lat, vecs[i].exp_data, $sformatf("vec%0d", i));

        // Simultaneous requests: MEM byte load first, IF word read after DONE + IDLE.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = LEN_B; mem_addr = 32'h80;
        if_req  = 1'b1; if_addr = 32'h300;
        cyc = 0; seen = 1'b0; any_done = 1'b0;
        while (!seen && cyc < 16) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("both mem ram_a", ram_a, 32'h80);
            if (if_done) any_done = 1'b1;
            if (mem_done) seen = 1'b1;
        end
        chk("both mem latency", 32'(cyc - 1), 32'd2);
        chk("both mem rdata", mem_rdata, 32'h0000_00F0);
        chk("both if early", {31'b0, any_done}, 32'h0);
        mem_req = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("both if not yet", ram_a, 32'h0);
            if (cyc == 2) chk("both if ram_a", ram_a, 32'h300);
            if (if_done) seen = 1'b1;
        end
        chk("both if timing", 32'(cyc), 32'd7);
        chk("both if data", if_data, 32'h8D7C_6B5A);
        if_req = 1'b0;
        @(negedge clk);

        // Flush two cycles after an IF accept.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0;
        any_done = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (if_done) any_done = 1'b1;
            if (c == 3) begin
                chk("flush pre ram_a", ram_a, 32'h2);
                if_flush = 1'b1;
            end
        end
        @(negedge clk);
        chk("flush ram_a", ram_a, 32'h0);
        if (if_done) any_done = 1'b1;
        if_req = 1'b0; if_flush = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (if_done) any_done = 1'b1;
        end
        chk("flush no if_done", {31'b0, any_done}, 32'h0);
        xact(1'b1, 1'b0, LEN_W, 32'h40, 32'h0, 1'b0, 5, model_load(32'h40, 4), "after flush");

        // Reset in the middle of a word store.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = LEN_W;
        mem_addr = 32'h600; mem_wdata = 32'hA1B2_C3D4;
        repeat (3) @(negedge clk);
        chk("rst pre ram_a", ram_a, 32'h602);
        rst = 1'b1;
        @(negedge clk);
        chk("rst ram_a", ram_a, 32'h0);
        chk("rst ram_wr", {31'b0, ram_wr}, 32'h0);
        chk("rst ram_dout", {24'b0, ram_dout}, 32'h0);
        chk("rst dones", {30'b0, if_done, mem_done}, 32'h0);
        chk("rst if_data", if_data, 32'h0);
        chk("rst mem_rdata", mem_rdata, 32'h0);
        snap = wr_count;
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst no writes", 32'(wr_count - snap), 32'h0);
        chk("rst byte3 kept", {24'b0, ram_byte(32'h603)}, 32'h77);
        chk("rst byte0 done", {24'b0, ram_byte(32'h600)}, 32'hD4);
        xact(1'b0, 1'b1, LEN_W, 32'h600, 32'h5566_7788, 1'b0, 4, 32'h5566_7788, "post rst st");
        xact(1'b0, 1'b0, LEN_W, 32'h600, 32'h0, 1'b0, 5, 32'h5566_7788, "post rst ld");

        // Random traffic against the reference model.
        for (int k = 0; k < 40; k++) begin
            r_is_if = ($urandom_range(0, 2) == 2);
            r_we    = !r_is_if && ($urandom_range(0, 1) == 1);
            r_len   = r_is_if ? LEN_W : 2'($urandom_range(0, 3));
            r_addr  = $urandom;
            if ($urandom_range(0, 3) == 0) r_addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            r_wdata = $urandom;
            r_flush = !r_is_if && ($urandom_range(0, 3) == 0);
            r_n     = byte_count(r_is_if, r_len);
            if (r_we) begin
                r_exp = (r_n == 4) ? r_wdata : (r_wdata & ((32'h1 << (8 * r_n)) - 32'h1));
                r_lat = r_n;
            end else begin
                r_exp = model_load(r_addr, r_n);
                r_lat = r_n + 1;
            end
            xact(r_is_if, r_we, r_len, r_addr, r_wdata, r_flush, r_lat, r_exp,
                 $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

- Single-owner controller for the CPU's byte-wide RAM port; serializes word, half and byte requests from the fetch stage (IF) and the memory stage (MEM) into per-byte RAM cycles.
- Sits between those two stages and the top-level RAM pins.
- MEM has priority; IF reads can be cancelled by a pipeline flush.
- Read data is returned raw and zero-extended; sign extension belongs to the memory stage.

## Interface
Parameters:
- ADDR_W, 32, address width
- none other

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  IF read request, level, held until if_done
- if_addr  in  32  IF read address (always 4 bytes)
- if_flush  in  1  cancel in-flight or pending IF read
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched word, little-endian
- mem_req  in  1  MEM request, level, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  byte count minus 1: 0 = byte, 1 = half, 3 = word; 2 is illegal, treated as 3
- mem_addr  in  32  MEM start address
- mem_wdata  in  32  store data; byte i = bits [8i+7:8i]
- mem_done  out  1  one-cycle pulse, access complete
- mem_rdata  out  32  load bytes, zero-extended above mem_len
- ram_din  in  8  RAM read byte
- ram_a  out  32  RAM address, registered
- ram_wr  out  1  RAM write enable, registered
- ram_dout  out  8  RAM write byte, registered

## Operation
- States: IDLE, RD, WR, DONE.
- Counters: cnt (issue index 0..3), rcv (capture index 0..3).
- Latched: owner (IF/MEM), base address, N = byte count, write data.

IDLE:
- mem_req=1 has priority: load to RD, store to WR.
- Otherwise if_req=1 and if_flush=0: RD with owner IF and N=4.
- The request is latched at the accepting edge. ram_a=addr, ram_wr=mem_we, ram_dout=wdata[7:0], cnt=1.

RD:
- Each edge while cnt<N: ram_a=base+cnt, cnt++.
- From the second edge after accept, capture ram_din into byte rcv, then rcv++.
- When byte N-1 is captured: go to DONE, pulse the owner's done, ram_a=0.

WR:
- Each edge while cnt<N: ram_a=base+cnt, ram_dout=byte cnt, cnt++.
- When cnt=N: ram_wr=0, ram_a=0, go to DONE, pulse mem_done.

DONE:
- Lasts exactly one cycle. Done is high and new requests are ignored.
- The requester must drop req during this cycle. Next state is IDLE.

Flush:
- if_flush=1 while owner=IF in RD: IDLE next edge, ram_a=0, no if_done, captured bytes discarded.
- Flush has no effect on MEM-owned operations.

General rules:
- Data outputs hold their last value until the next done.
- mem_rdata bytes above N are 0.
- Address arithmetic is modulo 2^32; wrap at 0xFFFFFFFF is permitted.

## Timing
- RAM model: samples ram_a/ram_wr/ram_dout at posedge. Read data for the address sampled at edge k is on ram_din until edge k+1.
- Accept edge is E0. Read byte i is issued at E_i and captured at E_{i+2}.
- Read: done high in the cycle after E_{N+1}, i.e. N+1 cycles after accept. Word = 5, half = 3, byte = 2.
- Write: done high in the cycle after E_N, i.e. N cycles after accept. Word = 4, byte = 1.
- Minimum spacing between accepts: done cycle plus one IDLE edge.
- Simultaneous mem_req and if_req in IDLE: MEM wins; IF waits, req held.
- Flush in the same cycle as if_done: done still pulses. The IF stage discards the data.
- Reset values: state IDLE, ram_a=0, ram_wr=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0, cnt=rcv=0.
- Reset mid-write aborts remaining bytes; ram_wr=0 the cycle after the reset edge.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE, RD, WR, DONE), owner encoding, mem_len encodings (LEN_B=0, LEN_H=1, LEN_W=3), ZeroWord.
- Single module; no sub-module is natural.
- Byte assembly and steering are small muxes inside the module.

## Test plan
- MEM word load at 0x100, RAM holds 0x11,0x22,0x33,0x44 -> ram_a 0x100..0x103 on consecutive cycles; mem_done 5 cycles after accept; mem_rdata=0x44332211.
- MEM half store 0xBEEF to 0x2001 -> ram_wr=1 for 2 cycles; bytes 0xEF@0x2001, 0xBE@0x2002; mem_done at cycle 2; ram_wr=0 and ram_a=0 afterwards.
- if_req and mem_req (byte load 0x80, RAM=0xF0) in the same cycle -> MEM served first, mem_rdata=0x000000F0; IF word read starts after DONE plus IDLE; if_done 5 cycles after its accept.
- IF word read at 0x0, if_flush asserted 2 cycles after accept -> IDLE next edge, no if_done, ram_a=0; a new if_req at 0x40 is then served normally.
- rst asserted during the 3rd byte of a MEM word store -> next cycle all outputs at reset values, no further RAM writes; a following store completes correctly.
- Word load at 0xFFFFFFFE -> ram_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; assembled data matches.
